// File: rtl/usb_buffer_pkg.sv
// Shared definitions for the USB packet buffer arbiter: FSM encoding and
// the buffer geometry / bus window constants used by the surrounding SoC.
package usb_buffer_pkg;

    // OPEN: round-robin between CPU and USB. LOCKED: USB owns the buffer.
    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam int          USB_PACKET_BUFFER_WORDS = 256;
    localparam logic [31:0] USB_BUFFER_BASE_ADDR    = 32'hc000_0000;

endpackage

// File: rtl/usb_buffer_arbiter_if.sv
// Bundle of every requester, RAM and debug signal around the buffer arbiter.
// Handshake: a requester holds *_req with address/sections/data stable; the
// access happens in the cycle *_grant is high (combinational, same cycle).
// A granted read (sections == 0) returns *_read_valid/*_read_value exactly
// one cycle later. Dropping *_req before a grant withdraws the request.
interface usb_buffer_arbiter_if
    import usb_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int SEC_WIDTH = DATA_WIDTH / 8;

    logic                  cpu_req;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [SEC_WIDTH-1:0]  cpu_write_sections;
    logic [DATA_WIDTH-1:0] cpu_write_value;
    logic                  cpu_grant;
    logic                  cpu_read_valid;
    logic [DATA_WIDTH-1:0] cpu_read_value;

    logic                  usb_req;
    logic [ADDR_WIDTH-1:0] usb_addr;
    logic [SEC_WIDTH-1:0]  usb_write_sections;
    logic [DATA_WIDTH-1:0] usb_write_value;
    logic                  usb_lock;
    logic                  usb_grant;
    logic                  usb_read_valid;
    logic [DATA_WIDTH-1:0] usb_read_value;
    logic                  usb_locked;

    logic                  ram_enable;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [SEC_WIDTH-1:0]  ram_write_sections;
    logic [DATA_WIDTH-1:0] ram_write_value;
    logic [DATA_WIDTH-1:0] ram_read_value;

    arb_state_e            dbg_state;
    logic                  dbg_ptr_usb;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_addr, cpu_write_sections, cpu_write_value,
        output cpu_grant, cpu_read_valid, cpu_read_value,
        input  usb_req, usb_addr, usb_write_sections, usb_write_value, usb_lock,
        output usb_grant, usb_read_valid, usb_read_value, usb_locked,
        output ram_enable, ram_addr, ram_write_sections, ram_write_value,
        input  ram_read_value,
        output dbg_state, dbg_ptr_usb
    );

    // Requester / RAM side.
    modport master (
        output cpu_req, cpu_addr, cpu_write_sections, cpu_write_value,
        input  cpu_grant, cpu_read_valid, cpu_read_value,
        output usb_req, usb_addr, usb_write_sections, usb_write_value, usb_lock,
        input  usb_grant, usb_read_valid, usb_read_value, usb_locked,
        input  ram_enable, ram_addr, ram_write_sections, ram_write_value,
        output ram_read_value,
        input  dbg_state, dbg_ptr_usb
    );
endinterface

// File: rtl/usb_buffer_arbiter_round_robin_pick.sv
// Two-way round-robin pick. Side A is the CPU, side B the USB engine.
// The pointer names the side that wins the next contended cycle and is
// moved to the opposite side of whoever was granted.
module round_robin_pick (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic force_a_i,
    output logic grant_a_o,
    output logic grant_b_o,
    output logic ptr_b_o
);
    logic ptr_b_q;
    logic ptr_b_d;

    // Grant decision and pointer update; a forced reset of the pointer to
    // side A wins over any grant-driven update.
    always_comb begin
        grant_a_o = 1'b0;
        grant_b_o = 1'b0;
        if (en_i) begin
            if (req_a_i && req_b_i) begin
                grant_a_o = !ptr_b_q;
                grant_b_o = ptr_b_q;
            end else begin
                grant_a_o = req_a_i;
                grant_b_o = req_b_i;
            end
        end
        ptr_b_d = ptr_b_q;
        if (force_a_i) begin
            ptr_b_d = 1'b0;
        end else if (grant_a_o) begin
            ptr_b_d = 1'b1;
        end else if (grant_b_o) begin
            ptr_b_d = 1'b0;
        end
    end

    // Pointer register; CPU has priority out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_b_q <= 1'b0;
        end else begin
            ptr_b_q <= ptr_b_d;
        end
    end

    assign ptr_b_o = ptr_b_q;
endmodule

// File: rtl/usb_buffer_arbiter.sv
// Shares the single-port USB packet buffer RAM between the CPU bus window
// and the USB packet engine. Round-robin in OPEN; in LOCKED the USB engine
// owns the RAM, except that after MAX_LOCK_CYCLES USB grants one waiting
// CPU access is let through so the CPU cannot starve.
module usb_buffer_arbiter
    import usb_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_LOCK_CYCLES = 64
) (
    input logic                 clk24,
    input logic                 reset_n,
    usb_buffer_arbiter_if.slave bus
);
    localparam int             CNT_W   = $clog2(MAX_LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK_CYCLES);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_cpu_q, rd_cpu_d;
    logic             rd_usb_q, rd_usb_d;

    logic cpu_grant;
    logic usb_grant;
    logic pick_en;
    logic pick_cpu;
    logic pick_usb;
    logic lock_drop;
    logic ptr_usb;

    // Grants are gated by reset_n so they fall the instant reset asserts.
    assign pick_en = reset_n && (state_q == ST_OPEN);

    round_robin_pick u_pick (
        .clk_i     (clk24),
        .rst_ni    (reset_n),
        .en_i      (pick_en),
        .req_a_i   (bus.cpu_req),
        .req_b_i   (bus.usb_req),
        .force_a_i (lock_drop),
        .grant_a_o (pick_cpu),
        .grant_b_o (pick_usb),
        .ptr_b_o   (ptr_usb)
    );

    // Lock FSM: next state, lock counter and the grant actually issued.
    // Dropping the lock never grants the CPU in the same cycle; the CPU
    // competes again in OPEN from the following cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cpu_grant = 1'b0;
        usb_grant = 1'b0;
        lock_drop = 1'b0;
        if (reset_n) begin
            case (state_q)
                ST_OPEN: begin
                    cpu_grant = pick_cpu;
                    usb_grant = pick_usb;
                    if (pick_usb && bus.usb_lock) begin
                        state_d = ST_LOCKED;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!bus.usb_lock) begin
                        usb_grant = bus.usb_req;
                        state_d   = ST_OPEN;
                        cnt_d     = '0;
                        lock_drop = 1'b1;
                    end else if ((cnt_q == CNT_MAX) && bus.cpu_req) begin
                        cpu_grant = 1'b1;
                        cnt_d     = '0;
                    end else if (bus.usb_req) begin
                        usb_grant = 1'b1;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = ST_OPEN;
            endcase
        end
    end

    // Read-owner flags: remember who issued a read so its data is routed
    // back the cycle after the grant.
    always_comb begin
        rd_cpu_d = cpu_grant && !(|bus.cpu_write_sections);
        rd_usb_d = usb_grant && !(|bus.usb_write_sections);
    end

    // State, counter and read-owner registers.
    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_OPEN;
            cnt_q    <= '0;
            rd_cpu_q <= 1'b0;
            rd_usb_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_cpu_q <= rd_cpu_d;
            rd_usb_q <= rd_usb_d;
        end
    end

    // RAM request mux; idle cycles drive all-zero address/sections/data.
    always_comb begin
        bus.ram_enable         = cpu_grant | usb_grant;
        bus.ram_addr           = '0;
        bus.ram_write_sections = '0;
        bus.ram_write_value    = '0;
        if (cpu_grant) begin
            bus.ram_addr           = bus.cpu_addr;
            bus.ram_write_sections = bus.cpu_write_sections;
            bus.ram_write_value    = bus.cpu_write_value;
        end else if (usb_grant) begin
            bus.ram_addr           = bus.usb_addr;
            bus.ram_write_sections = bus.usb_write_sections;
            bus.ram_write_value    = bus.usb_write_value;
        end
    end

    // Requester-facing outputs; read data only reaches the read owner.
    always_comb begin
        bus.cpu_grant      = cpu_grant;
        bus.usb_grant      = usb_grant;
        bus.cpu_read_valid = rd_cpu_q;
        bus.usb_read_valid = rd_usb_q;
        bus.cpu_read_value = rd_cpu_q ? bus.ram_read_value : '0;
        bus.usb_read_value = rd_usb_q ? bus.ram_read_value : '0;
        bus.usb_locked     = (state_q == ST_LOCKED);
        bus.dbg_state      = state_q;
        bus.dbg_ptr_usb    = ptr_usb;
    end
endmodule

// File: doc/usb_buffer_arbiter.md
Name: usb_buffer_arbiter

Overview:
- Shares the single-port USB packet buffer RAM (256 x 32-bit words, 1 KiB) between two requesters: the CPU data bus (memory-mapped window at 0xc0000000) and the USB packet engine.
- Round-robin arbitration. The USB engine can lock the buffer for a packet burst. A lock-length limit bounds CPU starvation.
- Sits between top-level bus decode, the usb engine and the buffer RAM. All buffer traffic runs in the clk24 domain.

Parameters:
- ADDR_WIDTH, 8, word address width (256 words).
- DATA_WIDTH, 32, word width; byte enables are DATA_WIDTH/8 wide.
- MAX_LOCK_CYCLES, 64, maximum consecutive USB grants under lock before one CPU slot is forced.

Ports:
- clk24  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cpu_req  input  1  CPU access request; hold with address/data stable until granted.
- cpu_addr  input  ADDR_WIDTH  CPU word address.
- cpu_write_sections  input  4  CPU byte enables; all-zero means read.
- cpu_write_value  input  DATA_WIDTH  CPU write data, already lane-shifted.
- cpu_grant  output  1  CPU access issued to RAM this cycle.
- cpu_read_valid  output  1  CPU read data valid (cycle after a CPU read grant).
- cpu_read_value  output  DATA_WIDTH  CPU read data.
- usb_req, usb_addr, usb_write_sections, usb_write_value  input  1/ADDR_WIDTH/4/DATA_WIDTH  USB engine request; same rules as the CPU signals.
- usb_lock  input  1  USB engine requests exclusive burst ownership.
- usb_grant, usb_read_valid, usb_read_value  output  1/1/DATA_WIDTH  USB equivalents of the CPU outputs.
- usb_locked  output  1  lock currently held by USB.
- ram_enable  output  1  RAM access this cycle.
- ram_addr  output  ADDR_WIDTH  RAM word address.
- ram_write_sections  output  4  RAM byte enables.
- ram_write_value  output  DATA_WIDTH  RAM write data.
- ram_read_value  input  DATA_WIDTH  RAM read data; synchronous, one-cycle latency.

Behaviour:
- Reset (async assert, sync release):
  - state=OPEN, priority pointer=CPU, lock counter=0, read-owner regs=0.
  - All grant, valid and locked outputs are 0; read_value outputs are 0.
- Grants are combinational from the current state and requests. At most one grant per cycle.
- ram_enable = cpu_grant | usb_grant. The granted requester's address, sections and data are muxed to ram_*. When nothing is granted, ram_* are all zero.
- Grant with write_sections==0 is a read:
  - The owner flag is registered.
  - Next cycle, that requester's read_valid=1 and read_value=ram_read_value.
  - The non-owner read_value stays 0.
  - Back-to-back reads are fully pipelined, one per cycle.
- Writes produce no read_valid. A write and a read to the same word in consecutive cycles returns the new data (RAM write-first).
- State OPEN:
  - Only one requester active: grant it.
  - Both active: grant the side named by the pointer, then flip the pointer to the other side.
  - A single-requester grant sets the pointer to the non-granted side.
  - usb_grant with usb_lock=1: next state LOCKED, counter=1.
- State LOCKED:
  - usb_locked=1. CPU is not granted while counter < MAX_LOCK_CYCLES.
  - Each usb_grant increments the counter.
  - usb_lock=0 (sampled any cycle): next state OPEN, counter cleared, pointer=CPU.
  - counter == MAX_LOCK_CYCLES and cpu_req=1: grant the CPU once (USB waits), counter resets to 0, stay LOCKED.
  - counter == MAX_LOCK_CYCLES and cpu_req=0: the USB continues to be granted and the counter saturates.
- Simultaneous usb_lock drop and cpu_req in LOCKED: the CPU is granted in the OPEN state the following cycle, not in the same cycle.
- Reset mid-read: the pending read_valid is dropped. Reset mid-lock: returns to OPEN.
- Requester protocol violation (request dropped before grant) is legal. The request is simply withdrawn with no side effects.

Decomposition:
- Shared package usb_buffer_pkg:
  - arbiter state encoding (OPEN, LOCKED);
  - USB_PACKET_BUFFER_WORDS = 256;
  - the buffer base address 0xc0000000.
- One natural sub-module: round_robin_pick, a 2-way pick with a pointer register and update-on-grant. Lock counter and read routing stay in the top module.

Test Plan:
- CPU-only read of addr 0x05 (RAM preloaded 0xdeadbeef) -> cpu_grant in cycle 0; cycle 1 cpu_read_valid=1, cpu_read_value=0xdeadbeef; usb outputs 0.
- CPU and USB both request every cycle for 6 cycles from reset -> grants alternate CPU,USB,CPU,USB,CPU,USB; exactly one ram_enable per cycle.
- USB write of 0x11223344 with sections=0b0011 to addr 0x10, then CPU read of 0x10 (old 0xaabbccdd) -> cpu_read_value=0xaabb3344.
- USB usb_lock=1 with continuous usb_req, CPU requesting, MAX_LOCK_CYCLES=4 -> four USB grants, one CPU grant, four USB grants; usb_locked=1 throughout.
- In LOCKED, drop usb_lock while cpu_req=1 -> usb_locked=0 next cycle, CPU granted that cycle, then pointer alternation resumes.
- Assert reset_n=0 the cycle after a CPU read grant -> cpu_read_valid=0 and all grants 0 immediately (asynchronous); after release, state OPEN and first contended grant goes to CPU.
